instr_prefetch_queue: RTL

// - Upstream fetch stage for the CPU control unit: reads 14-bit words from instruction ROM ahead of execution.
// - Buffers fetched words in a small FIFO; presents whole two-word commands (word0 opcode/reg, word1 address tail).
// - Replaces the control unit's per-instruction ROM read latency; jump/branch redirects flush the queue.

---
 rtl/instr_prefetch_queue.sv | 134 +++++++++++++
 1 files changed

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: reads instruction words from ROM ahead of execution and presents two-word commands.
// Optional build macro IPQ_STATS_EN adds saturating redirect/stall statistics outputs.
module instr_prefetch_queue #(
  parameter int DATA_W = 14,
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic              rom_rd,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] cmd_word0,
  output logic [DATA_W-1:0] cmd_word1,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              redir_en,
  input  logic [ADDR_W-1:0] redir_addr
`ifdef IPQ_STATS_EN
  ,
  output logic [15:0]       stat_redir,
  output logic [15:0]       stat_stall
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_FLUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic                inflight_q, inflight_d;
  logic [ADDR_W-1:0]   infl_addr_q, infl_addr_d;

  logic [DATA_W-1:0]   data_mem [DEPTH];
  logic [ADDR_W-1:0]   addr_mem [DEPTH];

  logic                pop, push;
  logic [CNT_W:0]      cnt_eff, occupancy, cnt_next;
  logic [PTR_W-1:0]    head_p1;

  // NOTE: every signal written here gets a default first so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (fetch_en) state_d = ST_FETCH;
      ST_FETCH: if (!fetch_en) state_d = ST_IDLE;
      ST_FLUSH: state_d = fetch_en ? ST_FETCH : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (redir_en) state_d = ST_FLUSH;

    cmd_valid = (count_q >= CNT_W'(2)) && (state_q != ST_FLUSH);
    pop       = cmd_valid && cmd_ready && !redir_en;
    push      = inflight_q && !redir_en;

    // Space is reserved for the word already in flight, crediting a pop happening this cycle.
    cnt_eff   = pop ? ({1'b0, count_q} - (CNT_W+1)'(2)) : {1'b0, count_q};
    occupancy = cnt_eff + {{CNT_W{1'b0}}, inflight_q};
    rom_rd    = (state_q == ST_FETCH) && !redir_en && (occupancy < (CNT_W+1)'(DEPTH));
    rom_addr  = pc_q;

    cnt_next    = cnt_eff + {{CNT_W{1'b0}}, push};
    count_d     = cnt_next[CNT_W-1:0];
    head_d      = pop  ? head_q + PTR_W'(2) : head_q;
    tail_d      = push ? tail_q + PTR_W'(1) : tail_q;
    pc_d        = rom_rd ? pc_q + ADDR_W'(1) : pc_q;
    inflight_d  = rom_rd;
    infl_addr_d = pc_q;

    if (redir_en) begin
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      pc_d       = redir_addr;
      inflight_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      inflight_q  <= inflight_d;
      infl_addr_q <= infl_addr_d;
    end
  end

  // NOTE: queue storage is not reset; occupancy is tracked by count_q and outputs are masked when invalid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[tail_q] <= rom_data;
      addr_mem[tail_q] <= infl_addr_q;
    end
  end

  assign head_p1   = head_q + PTR_W'(1);
  assign cmd_word0 = cmd_valid ? data_mem[head_q]  : '0;
  assign cmd_word1 = cmd_valid ? data_mem[head_p1] : '0;
  assign cmd_addr  = cmd_valid ? addr_mem[head_q]  : '0;

`ifdef IPQ_STATS_EN
  logic [15:0] stat_redir_q, stat_stall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_redir_q <= '0;
      stat_stall_q <= '0;
    end else begin
      if (redir_en && (stat_redir_q != 16'hFFFF)) stat_redir_q <= stat_redir_q + 16'd1;
      if (cmd_ready && !cmd_valid && (stat_stall_q != 16'hFFFF)) stat_stall_q <= stat_stall_q + 16'd1;
    end
  end

  assign stat_redir = stat_redir_q;
  assign stat_stall = stat_stall_q;
`endif
endmodule
